rf_write_arbiter: RTL and testbench



---
 rtl/rf_write_arbiter_if.sv | 40 ++++
 rtl/rf_write_arbiter.sv | 105 ++++++++++
 tb/tb_rf_write_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle between the writers/decode (master) and rf_write_arbiter (slave).
// RF_ARB_FORWARD_EN adds the qdat1/qdat2 bypass data outputs.
interface rf_write_arbiter_if;
  logic        valid0;
  logic        ready0;
  logic [4:0]  sel0;
  logic [31:0] dat0;
  logic        valid1;
  logic        ready1;
  logic [4:0]  sel1;
  logic [31:0] dat1;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  qsel1;
  logic [4:0]  qsel2;
  logic        qhit1;
  logic        qhit2;
  logic        starve;
`ifdef RF_ARB_FORWARD_EN
  logic [31:0] qdat1;
  logic [31:0] qdat2;
`endif

  modport master (
    output valid0, sel0, dat0, valid1, sel1, dat1, qsel1, qsel2,
    input  ready0, ready1, WEN, wsel, wdat, qhit1, qhit2, starve
`ifdef RF_ARB_FORWARD_EN
    , input qdat1, qdat2
`endif
  );

  modport slave (
    input  valid0, sel0, dat0, valid1, sel1, dat1, qsel1, qsel2,
    output ready0, ready1, WEN, wsel, wdat, qhit1, qhit2, starve
`ifdef RF_ARB_FORWARD_EN
    , output qdat1, qdat2
`endif
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-writer arbiter for the single register-file write port: registered output stage,
// fixed priority with a starvation guard, hazard query. Optional bypass data via RF_ARB_FORWARD_EN.
module rf_write_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  rf_write_arbiter_if.slave   bus
);

  typedef enum logic {NORMAL, STARVE} mode_e;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  mode_e             mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              wen_q, wen_d;
  logic [4:0]        wsel_q, wsel_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              gnt0, gnt1;
  logic              wen_out;

  assign cnt_inc = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    wen_d  = 1'b0;
    wsel_d = wsel_q;
    wdat_d = wdat_q;
    if (!RST) begin
      unique case (mode_q)
        NORMAL: begin
          if (bus.valid0) begin
            gnt0 = 1'b1;
            if (bus.valid1) begin
              cnt_d = cnt_inc;
              if (cnt_inc == MAX_CNT) mode_d = STARVE;
            end
          end else if (bus.valid1) begin
            gnt1  = 1'b1;
            cnt_d = '0;
          end
        end
        STARVE: begin
          // Requester 1 owns the port; requester 0 only fills cycles it leaves idle.
          if (bus.valid1) begin
            gnt1   = 1'b1;
            cnt_d  = '0;
            mode_d = NORMAL;
          end else if (bus.valid0) begin
            gnt0 = 1'b1;
          end
        end
        default: mode_d = NORMAL;
      endcase
      if (gnt0) begin
        wen_d  = (bus.sel0 != 5'd0);
        wsel_d = bus.sel0;
        wdat_d = bus.dat0;
      end else if (gnt1) begin
        wen_d  = (bus.sel1 != 5'd0);
        wsel_d = bus.sel1;
        wdat_d = bus.dat1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= NORMAL;
      cnt_q  <= '0;
      wen_q  <= 1'b0;
      wsel_q <= 5'd0;
      wdat_q <= 32'd0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      wen_q  <= wen_d;
      wsel_q <= wsel_d;
      wdat_q <= wdat_d;
    end
  end

  // Gating with RST keeps a write caught in the output stage away from the register file.
  assign wen_out    = wen_q & ~RST;

  assign bus.ready0 = gnt0;
  assign bus.ready1 = gnt1;
  assign bus.WEN    = wen_out;
  assign bus.wsel   = wsel_q;
  assign bus.wdat   = wdat_q;
  assign bus.starve = (mode_q == STARVE);
  assign bus.qhit1  = wen_out & (wsel_q == bus.qsel1) & (bus.qsel1 != 5'd0);
  assign bus.qhit2  = wen_out & (wsel_q == bus.qsel2) & (bus.qsel2 != 5'd0);

`ifdef RF_ARB_FORWARD_EN
  assign bus.qdat1  = bus.qhit1 ? wdat_q : 32'd0;
  assign bus.qdat2  = bus.qhit2 ? wdat_q : 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table followed by random traffic against a
// behavioural model, ending with a register-file contents comparison.
module tb_rf_write_arbiter;

  localparam int MAXW = 4;

  logic CLK;
  logic RST;
  rf_write_arbiter_if bus ();

  rf_write_arbiter #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, v0;
    logic [4:0]  s0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  s1;
    logic [31:0] d1;
    logic [4:0]  q1, q2;
    logic        r0, r1, wen, chkd;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic        h1, h2, st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v0, logic [4:0] s0, logic [31:0] d0,
                              logic v1, logic [4:0] s1, logic [31:0] d1,
                              logic [4:0] q1, logic [4:0] q2,
                              logic r0, logic r1, logic wen, logic chkd,
                              logic [4:0] wsel, logic [31:0] wdat,
                              logic h1, logic h2, logic st);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.s0 = s0; v.d0 = d0; v.v1 = v1; v.s1 = s1; v.d1 = d1;
    v.q1 = q1; v.q2 = q2; v.r0 = r0; v.r1 = r1; v.wen = wen; v.chkd = chkd;
    v.wsel = wsel; v.wdat = wdat; v.h1 = h1; v.h2 = h2; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [4:0] s0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] s1, input logic [31:0] d1,
                       input logic [4:0] q1, input logic [4:0] q2);
    @(negedge CLK);
    RST = rst; bus.valid0 = v0; bus.sel0 = s0; bus.dat0 = d0;
    bus.valid1 = v1; bus.sel1 = s1; bus.dat1 = d1; bus.qsel1 = q1; bus.qsel2 = q2;
    #1;
  endtask

  // Behavioural model state: what the output stage holds and the fairness bookkeeping.
  logic        m_wen, m_starve;
  logic [4:0]  m_wsel;
  logic [31:0] m_wdat;
  int          m_lost;
  logic [31:0] rf_m [32];
  logic [31:0] rf_d [32];

  initial begin
    logic        rst, v0, v1, e_r0, e_r1, e_wen, e_h1, e_h2;
    logic [4:0]  s0, s1, q1, q2;
    logic [31:0] d0, d1;

    RST = 1'b1; bus.valid0 = 0; bus.valid1 = 0; bus.sel0 = 0; bus.sel1 = 0;
    bus.dat0 = 0; bus.dat1 = 0; bus.qsel1 = 0; bus.qsel2 = 0;

    //             rst v0 s0 d0            v1 s1 d1        q1 q2  r0 r1 wen cd wsel wdat         h1 h2 st
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 32'h33,       1, 4, 32'h44,   0, 0,  0, 0, 0, 1, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 0, 1, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        5, 8,  0, 0, 1, 1, 5, 32'hDEADBEEF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        5, 0,  0, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 32'h1234, 0, 0,  0, 1, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 32'hA5A50007, 0, 0, 0,        0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        7, 8,  0, 0, 1, 1, 7, 32'hA5A50007, 1, 0, 0));
    // Both requesters held: four losses for requester 1, then one STARVE grant.
    tbl.push_back(mk(0, 1, 1, 32'h11,       1, 2, 32'h22,   0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h12,       1, 2, 32'h22,   1, 2,  1, 0, 1, 1, 1, 32'h11,       1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h13,       1, 2, 32'h22,   0, 0,  1, 0, 1, 1, 1, 32'h12,       0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h14,       1, 2, 32'h22,   0, 0,  1, 0, 1, 1, 1, 32'h13,       0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h15,       1, 2, 32'h22,   0, 0,  0, 1, 1, 1, 1, 32'h14,       0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 32'h16,       1, 2, 32'h22,   2, 1,  1, 0, 1, 1, 2, 32'h22,       1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 1, 1, 1, 32'h16,       0, 0, 0));
    // Reset right behind an accepted write discards it.
    tbl.push_back(mk(0, 1, 9, 32'h99,       0, 0, 0,        0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0, 0,        9, 0,  0, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        9, 0,  0, 0, 0, 1, 0, 0,            0, 0, 0));
    // Starvation with requester 1 withdrawing while STARVE is pending.
    tbl.push_back(mk(0, 1, 3, 32'h31,       1, 4, 32'h41,   0, 0,  1, 0, 0, 0, 0, 0,            0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h31,       1, 4, 32'h41,   0, 0,  1, 0, 1, 1, 3, 32'h31,       0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h31,       1, 4, 32'h41,   0, 0,  1, 0, 1, 1, 3, 32'h31,       0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h31,       1, 4, 32'h41,   0, 0,  1, 0, 1, 1, 3, 32'h31,       0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 32'h31,       0, 4, 32'h41,   3, 0,  1, 0, 1, 1, 3, 32'h31,       1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        0, 0,  0, 0, 1, 1, 3, 32'h31,       0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            1, 4, 32'h41,   0, 0,  0, 1, 0, 0, 0, 0,            0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,        4, 4,  0, 0, 1, 1, 4, 32'h41,       1, 1, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].s0, tbl[i].d0, tbl[i].v1, tbl[i].s1, tbl[i].d1,
            tbl[i].q1, tbl[i].q2);
      chk($sformatf("v%0d.ready0", i), {31'd0, bus.ready0}, {31'd0, tbl[i].r0});
      chk($sformatf("v%0d.ready1", i), {31'd0, bus.ready1}, {31'd0, tbl[i].r1});
      chk($sformatf("v%0d.WEN", i),    {31'd0, bus.WEN},    {31'd0, tbl[i].wen});
      chk($sformatf("v%0d.qhit1", i),  {31'd0, bus.qhit1},  {31'd0, tbl[i].h1});
      chk($sformatf("v%0d.qhit2", i),  {31'd0, bus.qhit2},  {31'd0, tbl[i].h2});
      chk($sformatf("v%0d.starve", i), {31'd0, bus.starve}, {31'd0, tbl[i].st});
      if (tbl[i].chkd) begin
        chk($sformatf("v%0d.wsel", i), {27'd0, bus.wsel}, {27'd0, tbl[i].wsel});
        chk($sformatf("v%0d.wdat", i), bus.wdat, tbl[i].wdat);
      end
`ifdef RF_ARB_FORWARD_EN
      chk($sformatf("v%0d.qdat1", i), bus.qdat1, tbl[i].h1 ? tbl[i].wdat : 32'd0);
      chk($sformatf("v%0d.qdat2", i), bus.qdat2, tbl[i].h2 ? tbl[i].wdat : 32'd0);
`endif
    end

    // Random traffic: requesters obey the hold rule, the model predicts every cycle.
    m_wen = 0; m_starve = 0; m_wsel = 0; m_wdat = 0; m_lost = 0;
    for (int r = 0; r < 32; r++) begin rf_m[r] = 32'd0; rf_d[r] = 32'd0; end
    v0 = 0; v1 = 0; s0 = 0; s1 = 0; d0 = 0; d1 = 0; e_r0 = 0; e_r1 = 0;
    for (int c = 0; c < 600; c++) begin
      rst = (c < 2) || ($urandom_range(0, 79) == 0);
      if (!(v0 && !e_r0) || $urandom_range(0, 9) == 0) begin
        v0 = ($urandom_range(0, 2) != 0);
        s0 = 5'($urandom_range(0, 7));
        d0 = $urandom;
      end
      if (!(v1 && !e_r1) || $urandom_range(0, 9) == 0) begin
        v1 = ($urandom_range(0, 2) != 0);
        s1 = 5'($urandom_range(0, 7));
        d1 = $urandom;
      end
      q1 = 5'($urandom_range(0, 7));
      q2 = 5'($urandom_range(0, 7));
      drive(rst, v0, s0, d0, v1, s1, d1, q1, q2);

      e_r0 = !rst && v0 && !(m_starve && v1);
      e_r1 = !rst && v1 && !e_r0;
      e_wen = m_wen && !rst;
      e_h1 = e_wen && (q1 == m_wsel) && (q1 != 0);
      e_h2 = e_wen && (q2 == m_wsel) && (q2 != 0);
      chk("rnd.ready0", {31'd0, bus.ready0}, {31'd0, e_r0});
      chk("rnd.ready1", {31'd0, bus.ready1}, {31'd0, e_r1});
      chk("rnd.WEN",    {31'd0, bus.WEN},    {31'd0, e_wen});
      chk("rnd.starve", {31'd0, bus.starve}, {31'd0, m_starve});
      chk("rnd.qhit1",  {31'd0, bus.qhit1},  {31'd0, e_h1});
      chk("rnd.qhit2",  {31'd0, bus.qhit2},  {31'd0, e_h2});
      if (e_wen) begin
        chk("rnd.wsel", {27'd0, bus.wsel}, {27'd0, m_wsel});
        chk("rnd.wdat", bus.wdat, m_wdat);
      end
`ifdef RF_ARB_FORWARD_EN
      chk("rnd.qdat1", bus.qdat1, e_h1 ? m_wdat : 32'd0);
      chk("rnd.qdat2", bus.qdat2, e_h2 ? m_wdat : 32'd0);
`endif
      if (e_wen) rf_m[m_wsel] = m_wdat;
      if (bus.WEN === 1'b1) rf_d[bus.wsel] = bus.wdat;

      @(posedge CLK);
      if (rst) begin
        m_wen = 0; m_wsel = 0; m_wdat = 0; m_starve = 0; m_lost = 0;
      end else begin
        m_wen = 0;
        if (e_r0) begin m_wen = (s0 != 0); m_wsel = s0; m_wdat = d0; end
        if (e_r1) begin m_wen = (s1 != 0); m_wsel = s1; m_wdat = d1; end
        if (e_r1) begin
          m_lost = 0; m_starve = 0;
        end else if (v0 && v1 && !m_starve) begin
          m_lost = (m_lost < MAXW) ? m_lost + 1 : MAXW;
          if (m_lost >= MAXW) m_starve = 1;
        end
      end
    end

    for (int r = 0; r < 8; r++) chk($sformatf("rf[%0d]", r), rf_d[r], rf_m[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
